// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide controller:
// func3 operation codes, FSM state encoding and special-case result constants.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add (multiply) or one restoring-division step
// per cycle on unsigned magnitudes loaded by the controller.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // acc_hi: product high word / 33-bit partial remainder.
  // acc_lo: multiplier shifting out, product low bits shifting in / dividend-quotient.
  logic [32:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] b_q;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_hi[31:0]} + (acc_lo[0] ? {1'b0, b_q} : 33'd0);
    div_shift = {acc_hi[31:0], acc_lo[31]};
    div_diff  = {acc_hi, acc_lo[31]} - {2'b00, b_q};
  end

  // NOTE: the datapath registers are reset as well; they are few and this keeps
  // X out of the result path after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      b_q    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= a_mag;
      b_q    <= b_mag;
    end else if (step) begin
      if (is_div) begin
        if (div_diff[33]) begin
          acc_hi <= div_shift;
          acc_lo <= {acc_lo[30:0], 1'b0};
        end else begin
          acc_hi <= div_diff[32:0];
          acc_lo <= {acc_lo[30:0], 1'b1};
        end
      end else begin
        acc_hi <= {1'b0, mul_sum[32:1]};
        acc_lo <= {mul_sum[0], acc_lo[31:1]};
      end
    end
  end

  assign hi = acc_hi[31:0];
  assign lo = acc_lo;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide controller in EX: stalls the pipeline while the
// iterative core runs. Define MULDIV_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  done_rd
);

  muldiv_state_e state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;

  logic        a_signed, b_signed, sign_a, sign_b, neg_d;
  logic [31:0] a_mag, b_mag;
  logic        accept, imm_hit, load, step;
  logic [31:0] imm_result, fix_result;
  logic [31:0] core_hi, core_lo;
  logic [63:0] prod_full;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  // 33x33 signed multiply; sign-extending both operands to 64 bits gives the same low 64 bits.
  assign fast_prod = $signed({{31{sign_a}}, sign_a, op_a}) * $signed({{31{sign_b}}, sign_b, op_b});
`endif

  assign accept = (state_q == ST_IDLE) & start & ~flush;

  always_comb begin
    a_signed = func3 inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = func3 inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sign_a   = a_signed & op_a[31];
    sign_b   = b_signed & op_b[31];
    a_mag    = cond_neg(sign_a, op_a);
    b_mag    = cond_neg(sign_b, op_b);
    // Remainder takes the dividend's sign; everything else the product of signs.
    neg_d    = (func3[2] & func3[1]) ? sign_a : (sign_a ^ sign_b);
  end

  // Results that are known at acceptance and bypass the iterative core.
  always_comb begin
    imm_hit    = 1'b0;
    imm_result = '0;
    if (func3[2] && op_b == '0) begin
      imm_hit    = 1'b1;
      imm_result = func3[1] ? op_a : ALL_ONES;
    end else if (func3[2] && !func3[0] && op_a == INT_MIN && op_b == ALL_ONES) begin
      imm_hit    = 1'b1;
      imm_result = func3[1] ? 32'd0 : INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!func3[2]) begin
      imm_hit    = 1'b1;
      imm_result = (func3 == OP_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    stall_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall_req = 1'b1;
          if (imm_hit) begin
            state_d = ST_DONE;
          end else begin
            load    = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall_req = 1'b1;
        step      = 1'b1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        stall_req = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  muldiv_iter_core u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (op_q[2]),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Multiplies negate the full 64-bit product so MULH* sees the correct borrow.
  always_comb begin
    prod_full = neg_q ? (~{core_hi, core_lo} + 64'd1) : {core_hi, core_lo};
    if (op_q[2]) begin
      fix_result = cond_neg(neg_q, op_q[1] ? core_hi : core_lo);
    end else begin
      fix_result = (op_q == OP_MUL) ? prod_full[31:0] : prod_full[63:32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      result  <= '0;
      done_rd <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q <= '0;
        op_q  <= func3;
        rd_q  <= rd;
        neg_q <= neg_d;
      end else if (step) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (accept && imm_hit) begin
        result  <= imm_result;
        done_rd <= rd;
      end else if (state_q == ST_FIX && !flush) begin
        result  <= fix_result;
        done_rd <= rd_q;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule
